// File: rtl/ld3320_pkg.sv
// ld3320_pkg: shared types and constants for the LD3320 parallel register bus.
package ld3320_pkg;
    localparam int BUS_W = 8;
    localparam int DEPTH = 256;
    localparam logic [7:0] ADDR_ASR_RESULT = 8'hC5;
    localparam logic [7:0] ADDR_INT = 8'h29;
    typedef enum logic [1:0] {IDLE, WR_LOW, RD_DRIVE, ABORT} state_t;
endpackage

// File: rtl/ld3320_sync.sv
// ld3320_sync: N-stage synchronizer; clears to zero so strobes look "not yet released" after reset.
module ld3320_sync #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r [N];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r[i] <= '0;
        end else begin
            r[0] <= d;
            for (int i = 1; i < N; i++) r[i] <= r[i-1];
        end
    end
    assign q = r[N-1];
endmodule

// File: rtl/ld3320_bus_responder.sv
// ld3320_bus_responder: chip-side LD3320 parallel bus responder with 256x8 register file.
module ld3320_bus_responder
    import ld3320_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] REG_RESET   = 8'h00,
    parameter int         MIN_PULSE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] p_in,
    output logic [7:0] p_out,
    output logic       p_oe,
    input  logic       a0,
    input  logic       csb,
    input  logic       wrb,
    input  logic       rdb,
    input  logic       loc_we,
    input  logic [7:0] loc_addr,
    input  logic [7:0] loc_data,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       proto_err,
    output logic       loc_collision
);
    logic             csb_s, wrb_s, rdb_s, a0_s;
    logic [BUS_W-1:0] p_s;
    state_t           state, state_n;
    logic [7:0]       cnt, addr_ptr;
    logic [7:0]       regs [DEPTH];
    logic             armed, commit, commit_data, set_err, collide, drv;

    ld3320_sync #(.N(SYNC_STAGES), .W(12)) u_sync (
        .clk(clk),
        .rst(rst),
        .d({csb, wrb, rdb, a0, p_in}),
        .q({csb_s, wrb_s, rdb_s, a0_s, p_s})
    );

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        set_err = 1'b0;
        case (state)
            IDLE: if (armed && !csb_s && !(wrb_s && rdb_s)) begin
                state_n = (!wrb_s && !rdb_s) ? ABORT : !wrb_s ? WR_LOW : RD_DRIVE;
                set_err = !wrb_s && !rdb_s;
            end
            WR_LOW: if (!rdb_s) begin
                state_n = ABORT;
                set_err = 1'b1;
            end else if (wrb_s) begin
                state_n = IDLE;
                commit  = cnt >= 8'(MIN_PULSE);
            end else if (csb_s) begin
                state_n = ABORT;
            end
            RD_DRIVE: if (!wrb_s) begin
                state_n = ABORT;
                set_err = 1'b1;
            end else if (rdb_s || csb_s) begin
                state_n = IDLE;
            end
            default: state_n = (csb_s && wrb_s && rdb_s) ? IDLE : ABORT;
        endcase
    end

    assign commit_data = commit && !a0_s;
    assign collide     = commit_data && loc_we && loc_addr == addr_ptr;
    assign drv         = state == RD_DRIVE && state_n == RD_DRIVE;

    // a strobe held low across reset must return high before it can start a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            armed         <= 1'b0;
            cnt           <= 8'd0;
            addr_ptr      <= REG_RESET;
            p_out         <= 8'h00;
            p_oe          <= 1'b0;
            wr_valid      <= 1'b0;
            wr_addr       <= 8'h00;
            wr_data       <= 8'h00;
            proto_err     <= 1'b0;
            loc_collision <= 1'b0;
        end else begin
            state         <= state_n;
            armed         <= armed | (wrb_s & rdb_s);
            cnt           <= state == IDLE ? 8'd1 : (state == WR_LOW && !wrb_s && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
            addr_ptr      <= (commit && a0_s) ? p_s : addr_ptr;
            p_oe          <= drv;
            p_out         <= drv ? (a0_s ? addr_ptr : regs[addr_ptr]) : 8'h00;
            wr_valid      <= commit_data;
            wr_addr       <= commit_data ? addr_ptr : wr_addr;
            wr_data       <= commit_data ? p_s : wr_data;
            proto_err     <= proto_err | set_err;
            loc_collision <= collide;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= REG_RESET;
        end else begin
            if (loc_we && !collide) regs[loc_addr] <= loc_data;
            if (commit_data) regs[addr_ptr] <= p_s;
        end
    end
endmodule

// File: tb/tb_ld3320_bus_responder.sv
// tb_ld3320_bus_responder: randomized bus/local traffic against a register-map reference model.
module tb_ld3320_bus_responder;
    localparam int SYNC = 2;
    localparam int MINP = 2;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] p_in = 8'h00, loc_addr = 8'h00, loc_data = 8'h00;
    logic       a0 = 1'b0, csb = 1'b1, wrb = 1'b1, rdb = 1'b1, loc_we = 1'b0;
    logic [7:0] p_out, wr_addr, wr_data;
    logic       p_oe, wr_valid, proto_err, loc_collision;

    logic [7:0]  mem [256];
    logic [7:0]  ptr;
    logic [15:0] got_q [$];
    int checks = 0, errors = 0;

    ld3320_bus_responder #(.SYNC_STAGES(SYNC), .REG_RESET(8'h00), .MIN_PULSE(MINP)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .p_out(p_out), .p_oe(p_oe), .a0(a0),
        .csb(csb), .wrb(wrb), .rdb(rdb), .loc_we(loc_we), .loc_addr(loc_addr),
        .loc_data(loc_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .proto_err(proto_err), .loc_collision(loc_collision)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_valid) got_q.push_back({wr_addr, wr_data});

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ptr = 8'h00;
    endtask

    task automatic check_commit(input bit exp, input logic [7:0] addr, input logic [7:0] data);
        check("wr_count", 16'(got_q.size()), 16'(exp));
        if (exp && got_q.size() == 1) check("wr_pair", got_q[0], {addr, data});
        got_q.delete();
    endtask

    task automatic bus_write(input bit a, input logic [7:0] d, input int w);
        bit ok;
        a0 = a; p_in = d; csb = 0; tick(2);
        wrb = 0; tick(w);
        wrb = 1; tick(SYNC + 2);
        csb = 1; tick(2);
        ok = w >= MINP;
        check_commit(ok && !a, ptr, d);
        if (ok && a) ptr = d;
        if (ok && !a) mem[ptr] = d;
    endtask

    task automatic write_with_local(input logic [7:0] d, input logic [7:0] la, input logic [7:0] ld);
        a0 = 0; p_in = d; csb = 0; tick(2);
        wrb = 0; tick(4);
        wrb = 1; tick(SYNC);
        loc_addr = la; loc_data = ld; loc_we = 1; tick(1);
        check("collision", 16'(loc_collision), 16'(la == ptr));
        loc_we = 0; tick(2);
        csb = 1; tick(2);
        check_commit(1, ptr, d);
        if (la != ptr) mem[la] = ld;
        mem[ptr] = d;
    endtask

    task automatic local_write(input logic [7:0] la, input logic [7:0] ld);
        loc_addr = la; loc_data = ld; loc_we = 1; tick(1);
        loc_we = 0; tick(1);
        mem[la] = ld;
        check_commit(0, 8'h00, 8'h00);
    endtask

    task automatic bus_read(input bit a);
        int n;
        a0 = a; csb = 0; tick(1);
        rdb = 0; n = 0;
        while (!p_oe && n < SYNC + 2) begin tick(1); n++; end
        check("oe_rise", 16'(p_oe), 16'(1));
        tick(2);
        check("rd_data", 16'(p_out), 16'(a ? ptr : mem[ptr]));
        rdb = 1; n = 0;
        while (p_oe && n < SYNC + 2) begin tick(1); n++; end
        check("oe_fall", 16'(p_oe), 16'(0));
        csb = 1; tick(2);
    endtask

    initial begin
        int op, hi;
        model_reset();
        tick(3); rst = 0; tick(SYNC + 3);
        check("rst_oe", 16'(p_oe), 16'(0));
        check("rst_pout", 16'(p_out), 16'(0));
        check("rst_valid", 16'(wr_valid), 16'(0));
        check("rst_err", 16'(proto_err), 16'(0));
        check("rst_coll", 16'(loc_collision), 16'(0));

        bus_write(1, 8'h37, 6);
        bus_write(0, 8'hA5, 6);
        bus_read(0);
        bus_read(1);
        bus_write(0, 8'hFF, 1);
        bus_read(0);

        bus_write(1, 8'h29, 4);
        write_with_local(8'h04, 8'h29, 8'h10);
        bus_read(0);
        write_with_local(8'h55, 8'h30, 8'h66);
        bus_read(0);
        bus_write(1, 8'h30, 3);
        bus_read(0);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: bus_write(1, 8'($urandom_range(0, 7)), $urandom_range(2, 6));
                1: bus_write(0, 8'($urandom), $urandom_range(2, 6));
                2: bus_read(1'($urandom));
                3: local_write(8'($urandom_range(0, 7)), 8'($urandom));
                4: bus_write(1'($urandom), 8'($urandom), 1);
                default: write_with_local(8'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
            endcase
        end
        check("err_clean", 16'(proto_err), 16'(0));

        csb = 0; tick(2);
        wrb = 0; rdb = 0; tick(4);
        check("err_set", 16'(proto_err), 16'(1));
        check("err_oe", 16'(p_oe), 16'(0));
        wrb = 1; rdb = 1; tick(1); csb = 1; tick(SYNC + 3);
        check_commit(0, 8'h00, 8'h00);
        bus_write(0, 8'h5A, 3);
        bus_read(0);
        check("err_sticky", 16'(proto_err), 16'(1));

        a0 = 0; csb = 0; tick(1); rdb = 0; tick(SYNC + 3);
        check("pre_rst_oe", 16'(p_oe), 16'(1));
        rst = 1; #1;
        check("rst_oe_async", 16'(p_oe), 16'(0));
        tick(2); rst = 0; model_reset(); hi = 0;
        for (int i = 0; i < 10; i++) begin tick(1); hi += int'(p_oe); end
        check("no_drive_held", 16'(hi), 16'(0));
        check("rst_err_clr", 16'(proto_err), 16'(0));
        rdb = 1; csb = 1; tick(SYNC + 2);
        bus_read(1);
        bus_write(1, 8'h37, 4);
        bus_read(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
